// File: rtl/pc_redirect_unit_if.sv
// Bundle between the ID stage and the PC redirect unit.
// The master side drives the ID-stage state and the comparator
// decision. The slave side (the redirect unit) returns the fetch
// address, the flush request and the statistics.
interface pc_redirect_unit_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 Stall;
    logic [31:0]          IDInstruction;
    logic [31:0]          IDPC;
    logic [31:0]          RsData;
    logic                 Branch;
    logic                 Taken;
    logic [31:0]          PC;
    logic [31:0]          PCPlus4;
    logic                 Flush;
    logic                 RedirectPending;
    logic [CNT_WIDTH-1:0] BranchCount;
    logic [CNT_WIDTH-1:0] TakenCount;

    modport master (
        output Stall, IDInstruction, IDPC, RsData, Branch, Taken,
        input  PC, PCPlus4, Flush, RedirectPending, BranchCount, TakenCount
    );

    modport slave (
        input  Stall, IDInstruction, IDPC, RsData, Branch, Taken,
        output PC, PCPlus4, Flush, RedirectPending, BranchCount, TakenCount
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the program counter, classifies the ID-stage
// instruction, computes the redirect target and selects the next PC.
// A redirect decided while the pipeline is stalled is parked in
// PendTarget and applied on the first unstalled edge. Saturating
// counters track applied branch decisions and applied redirects.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    pc_redirect_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pend_tgt_q, pend_tgt_d;
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    logic [5:0]           opcode_s;
    logic [5:0]           funct_s;
    logic                 is_jr_s;
    logic                 is_j_s;
    logic                 is_jump_s;
    logic                 take_s;
    logic                 pending_s;
    logic [31:0]          idpc4_s;
    logic [31:0]          br_offset_s;
    logic [31:0]          target_s;
    logic [31:0]          pc_plus4_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 enable
    );
        logic [CNT_WIDTH-1:0] result;
        if (enable && (value != {CNT_WIDTH{1'b1}})) begin
            result = value + CNT_WIDTH'(1);
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign pending_s  = (state_q == ST_PENDING);
    assign pc_plus4_s = pc_q + 32'd4;

    // Decode the ID instruction and compute the redirect target.
    always_comb begin
        opcode_s    = bus.IDInstruction[31:26];
        funct_s     = bus.IDInstruction[5:0];
        is_jr_s     = (opcode_s == OP_SPECIAL) && (funct_s == FN_JR);
        is_j_s      = (opcode_s == OP_J) || (opcode_s == OP_JAL);
        is_jump_s   = is_jr_s || is_j_s;
        take_s      = bus.Branch && (bus.Taken || is_jump_s);
        idpc4_s     = bus.IDPC + 32'd4;
        br_offset_s = {{14{bus.IDInstruction[15]}}, bus.IDInstruction[15:0], 2'b00};
        if (is_jr_s) begin
            // Misaligned register targets pass through unchanged.
            target_s = bus.RsData;
        end else if (is_j_s) begin
            target_s = {idpc4_s[31:28], bus.IDInstruction[25:0], 2'b00};
        end else begin
            target_s = idpc4_s + br_offset_s;
        end
    end

    // Next-state selection: stall capture/hold, pending replay, redirect or sequential fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        if (bus.Stall) begin
            if ((state_q == ST_IDLE) && take_s) begin
                // Park the redirect; the branch stays in ID until the stall drops.
                state_d    = ST_PENDING;
                pend_tgt_d = target_s;
            end else begin
                // Hold everything; a Take seen while pending is the same branch.
                state_d    = state_q;
                pend_tgt_d = pend_tgt_q;
            end
        end else begin
            bcnt_d = sat_inc(bcnt_q, bus.Branch || pending_s);
            tcnt_d = sat_inc(tcnt_q, take_s || pending_s);
            case (state_q)
                ST_PENDING: begin
                    // Replay the parked redirect and ignore the re-presented Take.
                    pc_d    = pend_tgt_q;
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (take_s) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pc_plus4_s;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    pc_d    = RESET_PC;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; an asynchronous reset discards any parked redirect.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
            bcnt_q     <= {CNT_WIDTH{1'b0}};
            tcnt_q     <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Flush marks the cycle whose edge loads a redirect target.
    always_comb begin
        if (Rst_n && !bus.Stall) begin
            bus.Flush = pending_s || take_s;
        end else begin
            bus.Flush = 1'b0;
        end
    end

    assign bus.PC              = pc_q;
    assign bus.PCPlus4         = pc_plus4_s;
    assign bus.RedirectPending = pending_s;
    assign bus.BranchCount     = bcnt_q;
    assign bus.TakenCount      = tcnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: a reference model pushes the expected
// post-edge state into a scoreboard queue as each cycle is driven; the
// entry is popped and compared after the edge. A second instance with a
// 4-bit counter width exercises counter saturation.
module tb_pc_redirect_unit;

    logic Clk = 1'b0;
    logic Rst_n;

    // 10 time-unit clock.
    always #5 Clk = ~Clk;

    pc_redirect_unit_if #(.CNT_WIDTH(16)) bus  ();
    pc_redirect_unit_if #(.CNT_WIDTH(4))  bus4 ();

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut4 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus4.slave)
    );

    localparam logic [31:0] I_BEQ = 32'h1022_0003; // beq  imm=+3
    localparam logic [31:0] I_BNE = 32'h1422_FFFE; // bne  imm=-2
    localparam logic [31:0] I_JAL = 32'h0C00_0040; // jal  index=0x40
    localparam logic [31:0] I_JR  = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] I_NOP = 32'h0000_0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic [15:0] m_bc;
    logic [15:0] m_tc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_pend = 1'b0;
        m_ptgt = 32'h0000_0000;
        m_bc   = 16'h0000;
        m_tc   = 16'h0000;
    endtask

    // Drive one cycle, check the combinational outputs, predict and check the post-edge state.
    task automatic run_cycle(input logic stall, input logic [31:0] instr, input logic [31:0] idpc,
                             input logic [31:0] rs, input logic br, input logic tk, input string tag);
        logic [5:0]  op;
        logic        is_jr;
        logic        is_j;
        logic        take;
        logic [31:0] tgt;
        logic [31:0] pc4;
        exp_t        e;
        exp_t        got;
        bus.Stall         = stall;
        bus.IDInstruction = instr;
        bus.IDPC          = idpc;
        bus.RsData        = rs;
        bus.Branch        = br;
        bus.Taken         = tk;
        #1;
        op    = instr[31:26];
        is_jr = (op == 6'b000000) && (instr[5:0] == 6'b001000);
        is_j  = (op == 6'b000010) || (op == 6'b000011);
        take  = br && (tk || is_jr || is_j);
        pc4   = idpc + 32'd4;
        if (is_jr) tgt = rs;
        else if (is_j) tgt = {pc4[31:28], instr[25:0], 2'b00};
        else tgt = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};

        check_eq({tag, " Flush"}, {31'd0, bus.Flush}, {31'd0, (!stall && (m_pend || take))});
        check_eq({tag, " PCPlus4"}, bus.PCPlus4, m_pc + 32'd4);

        if (stall) begin
            if (!m_pend && take) begin
                m_pend = 1'b1;
                m_ptgt = tgt;
            end
        end else begin
            if ((br || m_pend) && (m_bc != 16'hFFFF)) m_bc = m_bc + 16'd1;
            if ((take || m_pend) && (m_tc != 16'hFFFF)) m_tc = m_tc + 16'd1;
            if (m_pend) begin
                m_pc   = m_ptgt;
                m_pend = 1'b0;
            end else if (take) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.pend = m_pend; e.bc = m_bc; e.tc = m_tc;
        sb_q.push_back(e);

        @(posedge Clk);
        #1;
        got = sb_q.pop_front();
        check_eq({tag, " PC"}, bus.PC, got.pc);
        check_eq({tag, " RedirectPending"}, {31'd0, bus.RedirectPending}, {31'd0, got.pend});
        check_eq({tag, " BranchCount"}, {16'd0, bus.BranchCount}, {16'd0, got.bc});
        check_eq({tag, " TakenCount"}, {16'd0, bus.TakenCount}, {16'd0, got.tc});
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        Rst_n = 1'b0;
        bus.Stall = 1'b0; bus.IDInstruction = I_NOP; bus.IDPC = 32'd0;
        bus.RsData = 32'd0; bus.Branch = 1'b0; bus.Taken = 1'b0;
        bus4.Stall = 1'b0; bus4.IDInstruction = I_NOP; bus4.IDPC = 32'd0;
        bus4.RsData = 32'd0; bus4.Branch = 1'b0; bus4.Taken = 1'b0;
        model_reset();

        #12;
        check_eq("reset PC", bus.PC, 32'h0000_0000);
        check_eq("reset Flush", {31'd0, bus.Flush}, 32'd0);
        check_eq("reset RedirectPending", {31'd0, bus.RedirectPending}, 32'd0);
        check_eq("reset BranchCount", {16'd0, bus.BranchCount}, 32'd0);
        check_eq("reset TakenCount", {16'd0, bus.TakenCount}, 32'd0);
        #8;
        Rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_cycle(1'b0, I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, "idle");
        check_eq("idle PC seq end", bus.PC, 32'h0000_000C);

        run_cycle(1'b0, I_BEQ, 32'h0000_0100, 32'd0, 1'b1, 1'b1, "beq taken");
        check_eq("beq taken target", bus.PC, 32'h0000_0110);
        check_eq("beq taken BranchCount", {16'd0, bus.BranchCount}, 32'd1);
        check_eq("beq taken TakenCount", {16'd0, bus.TakenCount}, 32'd1);

        run_cycle(1'b0, I_BEQ, 32'h0000_0100, 32'd0, 1'b1, 1'b0, "beq not taken");
        check_eq("beq nt PC", bus.PC, 32'h0000_0114);
        check_eq("beq nt BranchCount", {16'd0, bus.BranchCount}, 32'd2);
        check_eq("beq nt TakenCount", {16'd0, bus.TakenCount}, 32'd1);

        run_cycle(1'b0, I_JAL, 32'h4000_0010, 32'd0, 1'b1, 1'b0, "jal");
        check_eq("jal target", bus.PC, 32'h4000_0100);

        run_cycle(1'b0, I_JR, 32'h4000_0100, 32'h0000_2000, 1'b1, 1'b0, "jr");
        check_eq("jr target", bus.PC, 32'h0000_2000);

        run_cycle(1'b0, I_JR, 32'h0000_2000, 32'h0000_2003, 1'b1, 1'b0, "jr misaligned");
        check_eq("jr misaligned target", bus.PC, 32'h0000_2003);

        // Redirect decided during a three-cycle stall.
        run_cycle(1'b1, I_BNE, 32'h0000_0200, 32'd0, 1'b1, 1'b1, "stall1");
        check_eq("stall1 PC frozen", bus.PC, 32'h0000_2003);
        check_eq("stall1 pending", {31'd0, bus.RedirectPending}, 32'd1);
        run_cycle(1'b1, I_BNE, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 1'b0, "stall2");
        run_cycle(1'b1, I_JR, 32'h0000_0200, 32'h0000_3000, 1'b1, 1'b1, "stall3");
        check_eq("stall3 PC frozen", bus.PC, 32'h0000_2003);
        run_cycle(1'b0, I_BNE, 32'h0000_0200, 32'd0, 1'b1, 1'b1, "stall release");
        check_eq("stall release target", bus.PC, 32'h0000_01FC);
        check_eq("stall release BranchCount", {16'd0, bus.BranchCount}, 32'd6);
        check_eq("stall release TakenCount", {16'd0, bus.TakenCount}, 32'd5);
        run_cycle(1'b0, I_NOP, 32'h0000_01FC, 32'd0, 1'b0, 1'b0, "after release");
        check_eq("after release PC", bus.PC, 32'h0000_0200);

        // Asynchronous reset while a redirect is parked.
        run_cycle(1'b1, I_BNE, 32'h0000_0200, 32'd0, 1'b1, 1'b1, "prereset stall");
        check_eq("prereset pending", {31'd0, bus.RedirectPending}, 32'd1);
        #3;
        bus.Stall = 1'b1; bus.Branch = 1'b0; bus.Taken = 1'b0; bus.IDInstruction = I_NOP;
        Rst_n = 1'b0;
        #1;
        check_eq("async reset PC", bus.PC, 32'h0000_0000);
        check_eq("async reset pending", {31'd0, bus.RedirectPending}, 32'd0);
        check_eq("async reset Flush", {31'd0, bus.Flush}, 32'd0);
        #4;
        Rst_n = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        run_cycle(1'b0, I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, "post reset 1");
        check_eq("post reset no redirect", bus.PC, 32'h0000_0004);
        run_cycle(1'b0, I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, "post reset 2");

        // Counter saturation on the 4-bit instance.
        bus4.Stall = 1'b0; bus4.IDInstruction = I_BEQ; bus4.IDPC = 32'h0000_0100;
        bus4.Branch = 1'b1; bus4.Taken = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge Clk);
            #1;
            if (i == 14) begin
                check_eq("sat4 BranchCount at 14", {28'd0, bus4.BranchCount}, 32'd14);
            end
            if (i == 15 || i == 17) begin
                check_eq("sat4 BranchCount", {28'd0, bus4.BranchCount}, 32'd15);
                check_eq("sat4 TakenCount", {28'd0, bus4.TakenCount}, 32'd15);
            end
        end
        bus4.Branch = 1'b0; bus4.Taken = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
